bcd_digit_formatter: RTL

- Sequential binary-to-BCD converter and digit formatter; sits directly upstream of the 8-digit seven-segment driver and produces its eight 6-bit per-digit codes.
- Converts an unsigned binary value to 8 BCD digits using shift-add-3 (double dabble), one bit per clock.
- Applies decimal-point placement and leading-zero blanking, then presents all eight codes atomically with a done pulse.
- Digit code format: bit5 = decimal point, bits4:1 = BCD digit, bit0 = digit lit (1) / blank (0).

---
 rtl/bcd_digit_formatter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_digit_formatter.sv
// ---------------------------------------------------------------------------
// bcd_digit_formatter
//
// Converts an unsigned binary value into eight BCD digits with the
// shift-add-3 (double dabble) algorithm, one input bit per clock. It then
// formats the digits into the 6-bit per-digit codes used by the 8-digit
// seven-segment driver. All eight codes are published together with a
// one-cycle done pulse.
//
// Digit code: [5] decimal point, [4:1] BCD digit, [0] lit (1) / blank (0).
//
// Optional feature macro: SSEG_LEAD_ZERO_BLANK_EN
//   defined   : leading-zero digits are blanked (bit0 = 0). Digit 0 and any
//               digit at or right of an enabled decimal point stay lit.
//   undefined : every digit is lit and zeros are shown.
//
// Parameters
//   BIN_W     width of the binary input, 4..27. Elaboration fails outside
//             this range.
//
// Ports
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   start     conversion request, sampled only while idle
//   bin       unsigned value, captured on the accepted start edge
//   dp_en     decimal point enable, captured with bin
//   dp_pos    digit index (0 = rightmost) carrying the decimal point
//   busy      high from the accepted start until done
//   done      one-cycle pulse; out0..out7 update in the same cycle
//   overflow  captured value was above 99,999,999 (digits saturate to 9)
//   out0..7   digit codes, out0 = rightmost digit
// ---------------------------------------------------------------------------
module bcd_digit_formatter #(
    parameter int BIN_W = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    input  logic             dp_en,
    input  logic [2:0]       dp_pos,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [5:0]       out0,
    output logic [5:0]       out1,
    output logic [5:0]       out2,
    output logic [5:0]       out3,
    output logic [5:0]       out4,
    output logic [5:0]       out5,
    output logic [5:0]       out6,
    output logic [5:0]       out7
);

    // The 32-bit BCD register holds at most 8 digits. A 27-bit input already
    // needs all of them plus the saturation path, so wider inputs are refused.
    if (BIN_W < 4 || BIN_W > 27) begin : g_bin_w_check
        $error("bcd_digit_formatter: BIN_W must be in the range 4..27");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        FORMAT  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [BIN_W-1:0] shift_reg;
    logic [31:0]      bcd_reg;
    logic [31:0]      bcd_adj;
    logic [4:0]       cnt_reg;
    logic             dp_en_reg;
    logic [2:0]       dp_pos_reg;
    logic             ovf_cap_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             overflow_reg;
    logic [5:0]       code_reg  [8];
    logic [5:0]       code_next [8];
    logic [3:0]       digit     [8];
    logic [7:0]       lit;

    // Per-nibble add-3 correction, digit selection (saturated to 9 on
    // overflow) and code assembly.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_reg[4*gi +: 4] + 4'd3
                                  : bcd_reg[4*gi +: 4];
        assign digit[gi]     = ovf_cap_reg ? 4'd9 : bcd_reg[4*gi +: 4];
        assign code_next[gi] = {dp_en_reg && (dp_pos_reg == 3'(gi)),
                                digit[gi], lit[gi]};
    end

`ifdef SSEG_LEAD_ZERO_BLANK_EN
    // nonzero_from[i]: some digit in positions i..7 is non-zero. A digit is a
    // leading zero exactly when this is false for its own position.
    logic [7:0] nonzero_from;

    for (genvar gi = 0; gi < 8; gi++) begin : g_blank
        if (gi == 7) begin : g_top
            assign nonzero_from[gi] = (digit[gi] != 4'd0);
        end else begin : g_lower
            assign nonzero_from[gi] = (digit[gi] != 4'd0) | nonzero_from[gi+1];
        end
        if (gi == 0) begin : g_units
            assign lit[gi] = 1'b1;
        end else begin : g_upper
            assign lit[gi] = nonzero_from[gi]
                           | (dp_en_reg && (3'(gi) <= dp_pos_reg));
        end
    end
`else
    assign lit = 8'hFF;
`endif

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start) state_next = CONVERT;
            CONVERT: if (cnt_reg == 5'(BIN_W - 1)) state_next = FORMAT;
            FORMAT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            dp_en_reg    <= 1'b0;
            dp_pos_reg   <= '0;
            ovf_cap_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                code_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            done_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        shift_reg   <= bin;
                        bcd_reg     <= '0;
                        cnt_reg     <= '0;
                        dp_en_reg   <= dp_en;
                        dp_pos_reg  <= dp_pos;
                        ovf_cap_reg <= (32'(bin) > 32'd99_999_999);
                        busy_reg    <= 1'b1;
                    end
                end
                CONVERT: begin
                    {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
                    cnt_reg              <= cnt_reg + 5'd1;
                end
                FORMAT: begin
                    for (int i = 0; i < 8; i++) begin
                        code_reg[i] <= code_next[i];
                    end
                    overflow_reg <= ovf_cap_reg;
                    done_reg     <= 1'b1;
                    busy_reg     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign overflow = overflow_reg;
    assign out0     = code_reg[0];
    assign out1     = code_reg[1];
    assign out2     = code_reg[2];
    assign out3     = code_reg[3];
    assign out4     = code_reg[4];
    assign out5     = code_reg[5];
    assign out6     = code_reg[6];
    assign out7     = code_reg[7];

endmodule
